// File: rtl/ddio_bidir_bus.sv
// ddio_bidir_bus: WIDTH-bit double-data-rate bidirectional pad controller.
// Rising edge carries high-phase data and falling edge carries low-phase data.
// A direction state machine inserts TURNAROUND idle cycles on every bus
// reversal. Transmit beats use a valid/ready handshake. Receive beats are
// captured only while the bus is in RX.
module ddio_bidir_bus #(
   parameter int unsigned WIDTH             = 8,
   parameter int unsigned TURNAROUND        = 1,
   parameter int unsigned EXTEND_OE_DISABLE = 0,
   parameter int unsigned POWER_UP_HIGH     = 0
) (
   input  logic             clk,
   input  logic             sclr_n,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] datain_h,
   input  logic [WIDTH-1:0] datain_l,
   input  logic             rx_en,
   output logic             rx_valid,
   output logic [WIDTH-1:0] dataout_h,
   output logic [WIDTH-1:0] dataout_l,
   output logic             oe_active,
   inout  wire  [WIDTH-1:0] padio
);

   // Value taken by every data register while sclr_n is low.
   localparam logic [WIDTH-1:0] RESET_VAL = (POWER_UP_HIGH != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   // Turnaround length, limited to 0..7 so a 3-bit counter is enough.
   localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND);

   // Direction of the shared bus.
   typedef enum logic [1:0] {
      ST_RX,
      ST_TURN_TX,
      ST_TX,
      ST_TURN_RX
   } state_t;

   state_t           state;
   logic [2:0]       turn_cnt;
   logic             oe_reg;
   logic             oe_neg;
   logic             oe_eff;
   logic [WIDTH-1:0] out_h;
   logic [WIDTH-1:0] out_l;
   logic [WIDTH-1:0] cap_h;
   logic [WIDTH-1:0] cap_l;
   logic             cap_pend;
   logic             capture_now;

   // A rising-edge capture happens only while the bus is in RX with rx_en set.
   assign capture_now = (state == ST_RX) && rx_en;

   // Direction FSM, transmit handshake, and output data/enable registers.
   // Each turnaround state lasts exactly TURNAROUND cycles.
   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         state    <= ST_RX;
         turn_cnt <= 3'd0;
         oe_reg   <= 1'b0;
         tx_ready <= 1'b0;
         out_h    <= RESET_VAL;
         out_l    <= RESET_VAL;
      end else begin
         case (state)
            ST_RX: begin
               tx_ready <= 1'b0;
               oe_reg   <= 1'b0;
               if (tx_valid) begin
                  if (TURNAROUND == 0) begin
                     state    <= ST_TX;
                     tx_ready <= 1'b1;
                  end else begin
                     state    <= ST_TURN_TX;
                     turn_cnt <= TURN_LOAD;
                  end
               end
            end
            ST_TURN_TX: begin
               if (turn_cnt <= 3'd1) begin
                  state    <= ST_TX;
                  turn_cnt <= 3'd0;
                  tx_ready <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt - 3'd1;
               end
            end
            ST_TX: begin
               if (tx_valid && tx_ready) begin
                  out_h  <= datain_h;
                  out_l  <= datain_l;
                  oe_reg <= 1'b1;
               end else if (!tx_valid) begin
                  oe_reg   <= 1'b0;
                  tx_ready <= 1'b0;
                  if (TURNAROUND == 0) begin
                     state <= ST_RX;
                  end else begin
                     state    <= ST_TURN_RX;
                     turn_cnt <= TURN_LOAD;
                  end
               end
            end
            ST_TURN_RX: begin
               tx_ready <= 1'b0;
               if (turn_cnt <= 3'd1) begin
                  state    <= ST_RX;
                  turn_cnt <= 3'd0;
               end else begin
                  turn_cnt <= turn_cnt - 3'd1;
               end
            end
            default: begin
               state    <= ST_RX;
               turn_cnt <= 3'd0;
               oe_reg   <= 1'b0;
               tx_ready <= 1'b0;
            end
         endcase
      end
   end

   // Rising-edge half of receive capture. The beat sampled at edge r, plus
   // its falling-edge partner, is published at edge r+1.
   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         cap_h     <= RESET_VAL;
         cap_pend  <= 1'b0;
         dataout_h <= RESET_VAL;
         dataout_l <= RESET_VAL;
         rx_valid  <= 1'b0;
      end else begin
         rx_valid <= cap_pend;
         if (cap_pend) begin
            dataout_h <= cap_h;
            dataout_l <= cap_l;
         end
         cap_pend <= capture_now;
         if (capture_now) begin
            cap_h <= padio;
         end
      end
   end

   // Falling-edge registers: delayed output enable for the optional
   // half-cycle extension, and the low-phase capture.
   always_ff @(negedge clk) begin
      if (!sclr_n) begin
         oe_neg <= 1'b0;
         cap_l  <= RESET_VAL;
      end else begin
         oe_neg <= oe_reg;
         if (cap_pend) begin
            cap_l <= padio;
         end
      end
   end

   // Effective enable. With the extension, the drive is held until the falling edge after oe_reg drops.
   assign oe_eff    = oe_reg | ((EXTEND_OE_DISABLE != 0) & oe_neg);
   assign oe_active = oe_eff;

   // DDR output mux. The clock level selects which half-beat is on the pads.
   assign padio = oe_eff ? (clk ? out_h : out_l) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ddio_bidir_bus.sv
// tb_ddio_bidir_bus: directed-vector bench for ddio_bidir_bus.
// Instance a: TURNAROUND=1, no OE extension, data resets to ones.
// Instance b: TURNAROUND=3, OE extension enabled, data resets to zeros.
module tb_ddio_bidir_bus;

   logic clk = 1'b0;

   logic       a_sclr_n, a_tx_valid, a_tx_ready, a_rx_en, a_rx_valid, a_oe_active;
   logic [7:0] a_datain_h, a_datain_l, a_dataout_h, a_dataout_l;
   logic       a_drv_en;
   logic [7:0] a_drv;
   wire  [7:0] a_pad;

   logic       b_sclr_n, b_tx_valid, b_tx_ready, b_rx_en, b_rx_valid, b_oe_active;
   logic [7:0] b_datain_h, b_datain_l, b_dataout_h, b_dataout_l;
   logic       b_drv_en;
   logic [7:0] b_drv;
   wire  [7:0] b_pad;

   int vector_count = 0;
   int miss_count   = 0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Bench-side pad drivers that model the far end of each bus.
   assign a_pad = a_drv_en ? a_drv : 8'bz;
   assign b_pad = b_drv_en ? b_drv : 8'bz;

   ddio_bidir_bus #(
      .WIDTH(8), .TURNAROUND(1), .EXTEND_OE_DISABLE(0), .POWER_UP_HIGH(1)
   ) dut_a (
      .clk(clk), .sclr_n(a_sclr_n), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .datain_h(a_datain_h), .datain_l(a_datain_l), .rx_en(a_rx_en),
      .rx_valid(a_rx_valid), .dataout_h(a_dataout_h), .dataout_l(a_dataout_l),
      .oe_active(a_oe_active), .padio(a_pad)
   );

   ddio_bidir_bus #(
      .WIDTH(8), .TURNAROUND(3), .EXTEND_OE_DISABLE(1), .POWER_UP_HIGH(0)
   ) dut_b (
      .clk(clk), .sclr_n(b_sclr_n), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .datain_h(b_datain_h), .datain_l(b_datain_l), .rx_en(b_rx_en),
      .rx_valid(b_rx_valid), .dataout_h(b_dataout_h), .dataout_l(b_dataout_l),
      .oe_active(b_oe_active), .padio(b_pad)
   );

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vector_count++;
      if (got !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advances to 1 time unit after the next rising edge.
   task automatic riseTick();
      @(posedge clk);
      #1;
   endtask

   // Advances to 1 time unit after the next falling edge.
   task automatic fallTick();
      @(negedge clk);
      #1;
   endtask

   // Directed stimulus, with expected values worked out by hand per edge.
   initial begin
      a_sclr_n = 1'b0; a_tx_valid = 1'b0; a_rx_en = 1'b0;
      a_datain_h = 8'h00; a_datain_l = 8'h00; a_drv_en = 1'b0; a_drv = 8'h00;
      b_sclr_n = 1'b0; b_tx_valid = 1'b0; b_rx_en = 1'b0;
      b_datain_h = 8'h00; b_datain_l = 8'h00; b_drv_en = 1'b0; b_drv = 8'h00;

      // Reset held for two cycles.
      riseTick();
      riseTick();
      fallTick();
      checkOutput("a_rst_dataout_h", 32'(a_dataout_h), 32'hFF);
      checkOutput("a_rst_dataout_l", 32'(a_dataout_l), 32'hFF);
      checkOutput("a_rst_rx_valid", 32'(a_rx_valid), 32'h0);
      checkOutput("a_rst_tx_ready", 32'(a_tx_ready), 32'h0);
      checkOutput("a_rst_oe", 32'(a_oe_active), 32'h0);
      checkOutput("b_rst_dataout_h", 32'(b_dataout_h), 32'h00);
      checkOutput("b_rst_dataout_l", 32'(b_dataout_l), 32'h00);
      checkOutput("b_rst_tx_ready", 32'(b_tx_ready), 32'h0);
      checkOutput("b_rst_oe", 32'(b_oe_active), 32'h0);
      a_sclr_n = 1'b1;
      b_sclr_n = 1'b1;

      // Instance a: two-beat burst with TURNAROUND=1.
      a_tx_valid = 1'b1; a_datain_h = 8'hA5; a_datain_l = 8'h5A;
      riseTick();
      checkOutput("a_burst_ready_turn", 32'(a_tx_ready), 32'h0);
      riseTick();
      checkOutput("a_burst_ready", 32'(a_tx_ready), 32'h1);
      checkOutput("a_burst_oe_pre", 32'(a_oe_active), 32'h0);
      riseTick();
      checkOutput("a_burst_oe1", 32'(a_oe_active), 32'h1);
      checkOutput("a_burst_pad_h1", 32'(a_pad), 32'hA5);
      a_datain_h = 8'hC3; a_datain_l = 8'h3C;
      fallTick();
      checkOutput("a_burst_pad_l1", 32'(a_pad), 32'h5A);
      riseTick();
      checkOutput("a_burst_pad_h2", 32'(a_pad), 32'hC3);
      checkOutput("a_burst_oe2", 32'(a_oe_active), 32'h1);
      a_tx_valid = 1'b0;
      fallTick();
      checkOutput("a_burst_pad_l2", 32'(a_pad), 32'h3C);
      checkOutput("a_burst_oe_l2", 32'(a_oe_active), 32'h1);
      riseTick();
      checkOutput("a_release_oe", 32'(a_oe_active), 32'h0);
      checkOutput("a_release_ready", 32'(a_tx_ready), 32'h0);

      // Instance a: receive one beat (0x11 high phase, 0x22 low phase).
      riseTick();
      a_rx_en = 1'b1; a_drv_en = 1'b1; a_drv = 8'h11;
      riseTick();
      checkOutput("a_rx_valid_early", 32'(a_rx_valid), 32'h0);
      a_drv = 8'h22;
      fallTick();
      a_rx_en = 1'b0; a_drv = 8'h33;
      riseTick();
      checkOutput("a_rx_dataout_h", 32'(a_dataout_h), 32'h11);
      checkOutput("a_rx_dataout_l", 32'(a_dataout_l), 32'h22);
      checkOutput("a_rx_valid", 32'(a_rx_valid), 32'h1);
      riseTick();
      checkOutput("a_rx_valid_drop", 32'(a_rx_valid), 32'h0);
      checkOutput("a_rx_hold_h", 32'(a_dataout_h), 32'h11);
      checkOutput("a_rx_hold_l", 32'(a_dataout_l), 32'h22);
      a_drv_en = 1'b0;

      // Instance a: reset during the second beat of a four-beat burst.
      a_tx_valid = 1'b1; a_datain_h = 8'h01; a_datain_l = 8'h02;
      riseTick();
      riseTick();
      checkOutput("a_mid_ready", 32'(a_tx_ready), 32'h1);
      riseTick();
      checkOutput("a_mid_pad_h1", 32'(a_pad), 32'h01);
      a_datain_h = 8'h03; a_datain_l = 8'h04;
      riseTick();
      checkOutput("a_mid_pad_h2", 32'(a_pad), 32'h03);
      a_datain_h = 8'h05; a_datain_l = 8'h06;
      a_sclr_n = 1'b0;
      fallTick();
      checkOutput("a_mid_pad_l2", 32'(a_pad), 32'h04);
      checkOutput("a_mid_oe_l2", 32'(a_oe_active), 32'h1);
      riseTick();
      checkOutput("a_mid_rst_oe", 32'(a_oe_active), 32'h0);
      checkOutput("a_mid_rst_ready", 32'(a_tx_ready), 32'h0);
      checkOutput("a_mid_rst_dataout_h", 32'(a_dataout_h), 32'hFF);
      checkOutput("a_mid_rst_dataout_l", 32'(a_dataout_l), 32'hFF);
      a_sclr_n = 1'b1; a_tx_valid = 1'b0;
      fallTick();
      checkOutput("a_mid_fall_oe", 32'(a_oe_active), 32'h0);
      riseTick();
      checkOutput("a_mid_after_oe", 32'(a_oe_active), 32'h0);
      checkOutput("a_mid_after_ready", 32'(a_tx_ready), 32'h0);
      // After reset, the machine restarts from RX with full turnaround latency.
      a_tx_valid = 1'b1;
      riseTick();
      checkOutput("a_restart_ready_turn", 32'(a_tx_ready), 32'h0);
      riseTick();
      checkOutput("a_restart_ready", 32'(a_tx_ready), 32'h1);
      a_tx_valid = 1'b0;

      // Instance b: one beat with TURNAROUND=3 and the OE extension.
      b_tx_valid = 1'b1; b_datain_h = 8'h96; b_datain_l = 8'h69;
      for (int i = 0; i < 3; i++) begin
         riseTick();
         checkOutput($sformatf("b_turn_tx_ready_%0d", i), 32'(b_tx_ready), 32'h0);
      end
      riseTick();
      checkOutput("b_ready", 32'(b_tx_ready), 32'h1);
      checkOutput("b_oe_pre", 32'(b_oe_active), 32'h0);
      riseTick();
      checkOutput("b_oe_beat", 32'(b_oe_active), 32'h1);
      checkOutput("b_pad_h", 32'(b_pad), 32'h96);
      b_tx_valid = 1'b0;
      fallTick();
      checkOutput("b_pad_l", 32'(b_pad), 32'h69);
      riseTick();
      checkOutput("b_ext_oe_high", 32'(b_oe_active), 32'h1);
      checkOutput("b_ext_ready", 32'(b_tx_ready), 32'h0);
      // tx_valid is raised during TURN_RX and must be ignored there.
      b_tx_valid = 1'b1;
      fallTick();
      checkOutput("b_ext_oe_fall", 32'(b_oe_active), 32'h0);
      b_rx_en = 1'b1; b_drv_en = 1'b1; b_drv = 8'h5C;
      for (int i = 0; i < 3; i++) begin
         riseTick();
         checkOutput($sformatf("b_turn_rx_ready_%0d", i), 32'(b_tx_ready), 32'h0);
      end
      // This edge is the single RX cycle that captures 0x5C.
      riseTick();
      checkOutput("b_rx_cycle_ready", 32'(b_tx_ready), 32'h0);
      checkOutput("b_rx_cycle_oe", 32'(b_oe_active), 32'h0);
      checkOutput("b_rx_cycle_valid", 32'(b_rx_valid), 32'h0);
      b_drv = 8'hC5;
      fallTick();
      b_rx_en = 1'b0;
      riseTick();
      checkOutput("b_rx_dataout_h", 32'(b_dataout_h), 32'h5C);
      checkOutput("b_rx_dataout_l", 32'(b_dataout_l), 32'hC5);
      checkOutput("b_rx_valid", 32'(b_rx_valid), 32'h1);
      checkOutput("b_turn2_ready_1", 32'(b_tx_ready), 32'h0);
      riseTick();
      checkOutput("b_rx_valid_once", 32'(b_rx_valid), 32'h0);
      checkOutput("b_turn2_ready_2", 32'(b_tx_ready), 32'h0);
      b_drv_en = 1'b0; b_datain_h = 8'h7E; b_datain_l = 8'hE7;
      riseTick();
      checkOutput("b_turn2_ready", 32'(b_tx_ready), 32'h1);
      checkOutput("b_turn2_oe_pre", 32'(b_oe_active), 32'h0);
      riseTick();
      checkOutput("b_turn2_pad_h", 32'(b_pad), 32'h7E);
      checkOutput("b_turn2_oe", 32'(b_oe_active), 32'h1);
      b_tx_valid = 1'b0;
      fallTick();
      checkOutput("b_turn2_pad_l", 32'(b_pad), 32'hE7);
      riseTick();
      checkOutput("b_turn2_ext_oe_high", 32'(b_oe_active), 32'h1);
      fallTick();
      checkOutput("b_turn2_ext_oe_fall", 32'(b_oe_active), 32'h0);

      riseTick();
      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
